// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the Mini-MIPS multi-cycle controller and its datapath.
// Carries the instruction fields, the memory handshake and every control line.
// When CTRL_PERF_CNT_EN is defined the bundle also carries the two
// performance counters.
interface mips_multicycle_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        mem_ready;
  logic        ir_write;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  pc_src;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_dst;
  logic        reg_write;
  logic        illegal;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;
`endif

  // Controller side: consumes instruction fields and handshake, drives controls.
  modport master (
    input  opcode, funct, rt, rd, mem_ready,
    output ir_write, pc_write, pc_write_cond, pc_src, mem_read, mem_write,
           iord, mem_to_reg, alu_src_a, alu_src_b, alu_op, reg_dst,
           reg_write, illegal
`ifdef CTRL_PERF_CNT_EN
    , output retired_cnt, stall_cnt
`endif
  );

  // Datapath side: mirror image of the controller.
  modport slave (
    output opcode, funct, rt, rd, mem_ready,
    input  ir_write, pc_write, pc_write_cond, pc_src, mem_read, mem_write,
           iord, mem_to_reg, alu_src_a, alu_src_b, alu_op, reg_dst,
           reg_write, illegal
`ifdef CTRL_PERF_CNT_EN
    , input retired_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the Mini-MIPS datapath.
// Sequences fetch, decode, ALU, memory and PC control.  mem_ready stretches
// FETCH, MEM_RD and MEM_WR.  Writes to register $0 are suppressed in the
// write-back states without altering the state sequence.
// TRAP_HOLD = 1 makes TRAP absorbing until reset; 0 returns to IDLE.
// Optional macro CTRL_PERF_CNT_EN adds retired_cnt / stall_cnt counters.
module mips_multicycle_ctrl #(
  parameter bit TRAP_HOLD = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JUMP      = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_r;
  state_t state_s;
  logic   is_sw_r;

  logic       ir_write_s;
  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic [1:0] pc_src_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       iord_s;
  logic       mem_to_reg_s;
  logic       alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic       reg_dst_s;
  logic       reg_write_s;
  logic       illegal_s;

  // Supported R-type functions: add, sub, and, or, slt.
  function automatic logic funct_ok(input logic [5:0] f);
    logic ok;
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: ok = 1'b1;
      default:                                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // State register; async reset drops every control line immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Remember whether the decoded memory instruction is a store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_sw_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      is_sw_r <= (bus.opcode == OP_SW);
    end else begin
      is_sw_r <= is_sw_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:   state_s = S_FETCH;
      S_FETCH:  state_s = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_s = funct_ok(bus.funct) ? S_R_EXEC : S_TRAP;
          OP_LW, OP_SW: state_s = S_MEM_ADDR;
          OP_BEQ:       state_s = S_BRANCH;
          OP_ADDI:      state_s = S_ADDI_EXEC;
          OP_J:         state_s = S_JUMP;
          default:      state_s = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_s = is_sw_r ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    state_s = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:    state_s = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_MEM_WB:    state_s = S_FETCH;
      S_R_EXEC:    state_s = S_R_WB;
      S_R_WB:      state_s = S_FETCH;
      S_BRANCH:    state_s = S_FETCH;
      S_ADDI_EXEC: state_s = S_ADDI_WB;
      S_ADDI_WB:   state_s = S_FETCH;
      S_JUMP:      state_s = S_FETCH;
      S_TRAP:      state_s = TRAP_HOLD ? S_TRAP : S_IDLE;
      default:     state_s = S_IDLE;
    endcase
  end

  // Moore output decode; FETCH commits IR/PC only on the mem_ready cycle and
  // write-back to $0 is masked.
  always_comb begin
    ir_write_s      = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    pc_src_s        = 2'b00;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    iord_s          = 1'b0;
    mem_to_reg_s    = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 2'b00;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    illegal_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        ir_write_s = 1'b0;
      end
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        ir_write_s  = bus.mem_ready;
        pc_write_s  = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_b_s = 2'b11;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      S_MEM_RD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg_s = 1'b1;
        reg_dst_s    = 1'b0;
        reg_write_s  = (bus.rt != 5'd0);
      end
      S_R_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
      end
      S_R_WB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = (bus.rd != 5'd0);
      end
      S_ADDI_WB: begin
        reg_dst_s   = 1'b0;
        reg_write_s = (bus.rt != 5'd0);
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 2'b01;
        pc_write_cond_s = 1'b1;
        pc_src_s        = 2'b01;
      end
      S_JUMP: begin
        pc_write_s = 1'b1;
        pc_src_s   = 2'b10;
      end
      S_TRAP: begin
        illegal_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b0;
      end
    endcase
  end

  assign bus.ir_write      = ir_write_s;
  assign bus.pc_write      = pc_write_s;
  assign bus.pc_write_cond = pc_write_cond_s;
  assign bus.pc_src        = pc_src_s;
  assign bus.mem_read      = mem_read_s;
  assign bus.mem_write     = mem_write_s;
  assign bus.iord          = iord_s;
  assign bus.mem_to_reg    = mem_to_reg_s;
  assign bus.alu_src_a     = alu_src_a_s;
  assign bus.alu_src_b     = alu_src_b_s;
  assign bus.alu_op        = alu_op_s;
  assign bus.reg_dst       = reg_dst_s;
  assign bus.reg_write     = reg_write_s;
  assign bus.illegal       = illegal_s;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt_r;
  logic [31:0] stall_cnt_r;
  logic        retire_s;
  logic        stall_s;

  // Retirement is the exit from a terminal state; a stall is a waiting memory cycle.
  always_comb begin
    retire_s = 1'b0;
    stall_s  = 1'b0;
    case (state_r)
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: retire_s = 1'b1;
      S_MEM_WR: begin
        retire_s = bus.mem_ready;
        stall_s  = !bus.mem_ready;
      end
      S_FETCH, S_MEM_RD: stall_s = !bus.mem_ready;
      default: retire_s = 1'b0;
    endcase
  end

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt_r <= 32'd0;
      stall_cnt_r   <= 32'd0;
    end else begin
      retired_cnt_r <= retired_cnt_r + {31'd0, retire_s};
      stall_cnt_r   <= stall_cnt_r + {31'd0, stall_s};
    end
  end

  assign bus.retired_cnt = retired_cnt_r;
  assign bus.stall_cnt   = stall_cnt_r;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: a per-cycle scoreboard of
// expected control vectors plus scenario-specific inline checks.
module tb_mips_multicycle_ctrl;

  typedef enum int {
    T_IDLE, T_FETCH, T_DECODE, T_MEM_ADDR, T_MEM_RD, T_MEM_WB, T_MEM_WR,
    T_R_EXEC, T_R_WB, T_BRANCH, T_ADDI_EXEC, T_ADDI_WB, T_JUMP, T_TRAP
  } tstate_t;

  typedef struct {
    logic [16:0] v;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   rw_seen;
  exp_t exp_q[$];
  logic [16:0] obs;

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl #(.TRAP_HOLD(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.pc_src,
                bus.mem_read, bus.mem_write, bus.iord, bus.mem_to_reg,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_dst,
                bus.reg_write, bus.illegal};

  function automatic logic [16:0] mk(input logic ir, input logic pw, input logic pwc,
                                     input logic [1:0] ps, input logic mr, input logic mw,
                                     input logic io, input logic m2r, input logic asa,
                                     input logic [1:0] asb, input logic [1:0] aop,
                                     input logic rdst, input logic rw, input logic ill);
    return {ir, pw, pwc, ps, mr, mw, io, m2r, asa, asb, aop, rdst, rw, ill};
  endfunction

  // Reference control vector per state, straight from the state table.
  function automatic logic [16:0] exp_vec(input tstate_t st, input logic mrdy, input logic dz);
    case (st)
      T_FETCH:     return mk(mrdy, mrdy, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
      T_DECODE:    return mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
      T_MEM_ADDR,
      T_ADDI_EXEC: return mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
      T_MEM_RD:    return mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      T_MEM_WR:    return mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      T_MEM_WB:    return mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, !dz, 1'b0);
      T_R_EXEC:    return mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
      T_R_WB:      return mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, !dz, 1'b0);
      T_ADDI_WB:   return mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, !dz, 1'b0);
      T_BRANCH:    return mk(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
      T_JUMP:      return mk(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      T_TRAP:      return mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
      default:     return 17'd0;
    endcase
  endfunction

  // Scoreboard consumer: one expected vector per clock, compared mid-cycle.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.reg_write === 1'b1) rw_seen++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s: outputs got %05h expected %05h", e.name, obs, e.v);
        end
      end
    end
  endtask

  // Drive one cycle of stimulus and queue the vector expected for it.
  task automatic drive(input logic mr, input tstate_t st, input logic dz, input string nm);
    exp_t e;
    bus.mem_ready = mr;
    e.v = exp_vec(st, mr, dz);
    e.name = nm;
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH; fw/mw are wait cycles in FETCH and MEM_RD/MEM_WR.
  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] t, input logic [4:0] d,
                           input int fw, input int mw, input int trap_extra);
    int exp_rw;
    logic rnd;
    bus.opcode = op;
    bus.funct  = fn;
    bus.rt     = t;
    bus.rd     = d;
    rw_seen    = 0;
    exp_rw     = 0;
    for (int i = 0; i < fw; i++) drive(1'b0, T_FETCH, 1'b0, {nm, ":fetch_wait"});
    drive(1'b1, T_FETCH, 1'b0, {nm, ":fetch"});
    rnd = 1'($urandom_range(0, 1));
    drive(rnd, T_DECODE, 1'b0, {nm, ":decode"});
    rnd = 1'($urandom_range(0, 1));
    if (op == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                            fn == 6'b100101 || fn == 6'b101010)) begin
      drive(rnd, T_R_EXEC, 1'b0, {nm, ":r_exec"});
      drive(rnd, T_R_WB, (d == 5'd0), {nm, ":r_wb"});
      exp_rw = (d != 5'd0) ? 1 : 0;
    end else if (op == 6'b100011) begin
      drive(rnd, T_MEM_ADDR, 1'b0, {nm, ":mem_addr"});
      for (int i = 0; i < mw; i++) drive(1'b0, T_MEM_RD, 1'b0, {nm, ":mem_rd_wait"});
      drive(1'b1, T_MEM_RD, 1'b0, {nm, ":mem_rd"});
      drive(rnd, T_MEM_WB, (t == 5'd0), {nm, ":mem_wb"});
      exp_rw = (t != 5'd0) ? 1 : 0;
    end else if (op == 6'b101011) begin
      drive(rnd, T_MEM_ADDR, 1'b0, {nm, ":mem_addr"});
      for (int i = 0; i < mw; i++) drive(1'b0, T_MEM_WR, 1'b0, {nm, ":mem_wr_wait"});
      drive(1'b1, T_MEM_WR, 1'b0, {nm, ":mem_wr"});
    end else if (op == 6'b000100) begin
      drive(rnd, T_BRANCH, 1'b0, {nm, ":branch"});
    end else if (op == 6'b001000) begin
      drive(rnd, T_ADDI_EXEC, 1'b0, {nm, ":addi_exec"});
      drive(rnd, T_ADDI_WB, (t == 5'd0), {nm, ":addi_wb"});
      exp_rw = (t != 5'd0) ? 1 : 0;
    end else if (op == 6'b000010) begin
      drive(rnd, T_JUMP, 1'b0, {nm, ":jump"});
    end else begin
      for (int i = 0; i <= trap_extra; i++) begin
        rnd = 1'($urandom_range(0, 1));
        drive(rnd, T_TRAP, 1'b0, {nm, ":trap"});
      end
    end
    checks++;
    if (rw_seen !== exp_rw) begin
      errors++;
      $display("FAIL %s:reg_write_cycles got %0d expected %0d", nm, rw_seen, exp_rw);
    end
  endtask

  task automatic test_reset();
    bus.mem_ready = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL reset_hold: outputs got %05h expected %05h", obs, 17'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL reset_idle: outputs got %05h expected %05h", obs, 17'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_r_type();
    run_instr("add_rd3", 6'b000000, 6'b100000, 5'd9, 5'd3, 0, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait2", 6'b100011, 6'b000000, 5'd5, 5'd0, 0, 2, 0);
  endtask

  task automatic test_zero_dest();
    run_instr("addi_rt0", 6'b001000, 6'b000000, 5'd0, 5'd4, 0, 0, 0);
    run_instr("lw_rt0", 6'b100011, 6'b000000, 5'd0, 5'd4, 1, 0, 0);
    run_instr("add_rd0", 6'b000000, 6'b100000, 5'd6, 5'd0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_instr("sub", 6'b000000, 6'b100010, 5'd1, 5'd2, 0, 0, 0);
    run_instr("and", 6'b000000, 6'b100100, 5'd3, 5'd4, 2, 0, 0);
    run_instr("or",  6'b000000, 6'b100101, 5'd5, 5'd6, 0, 0, 0);
    run_instr("slt", 6'b000000, 6'b101010, 5'd7, 5'd31, 0, 0, 0);
    run_instr("addi_rt7", 6'b001000, 6'b000000, 5'd7, 5'd0, 0, 0, 0);
    run_instr("beq", 6'b000100, 6'b000000, 5'd1, 5'd0, 1, 0, 0);
    run_instr("j", 6'b000010, 6'b000000, 5'd0, 5'd0, 0, 0, 0);
    run_instr("sw_wait1", 6'b101011, 6'b000000, 5'd8, 5'd0, 0, 1, 0);
    run_instr("lw", 6'b100011, 6'b000000, 5'd12, 5'd0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_write();
    exp_t e;
    bus.opcode = 6'b101011;
    bus.funct  = 6'b000000;
    bus.rt     = 5'd2;
    bus.rd     = 5'd0;
    drive(1'b1, T_FETCH, 1'b0, "sw_rst:fetch");
    drive(1'b0, T_DECODE, 1'b0, "sw_rst:decode");
    drive(1'b1, T_MEM_ADDR, 1'b0, "sw_rst:mem_addr");
    bus.mem_ready = 1'b0;
    e.v = exp_vec(T_MEM_WR, 1'b0, 1'b0);
    e.name = "sw_rst:mem_wr";
    exp_q.push_back(e);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || obs !== 17'd0) begin
      errors++;
      $display("FAIL sw_rst:async_drop: outputs got %05h expected %05h", obs, 17'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 17'd0) begin
      errors++;
      $display("FAIL sw_rst:idle: outputs got %05h expected %05h", obs, 17'd0);
    end
    @(posedge clk);
    #1;
    run_instr("add_after_rst", 6'b000000, 6'b100000, 5'd1, 5'd3, 0, 0, 0);
  endtask

  task automatic test_trap();
    run_instr("rtype_funct0", 6'b000000, 6'b000000, 5'd1, 5'd3, 0, 0, 4);
    do_reset();
    run_instr("op_111111", 6'b111111, 6'b100000, 5'd1, 5'd3, 1, 0, 6);
    do_reset();
    run_instr("add_after_trap", 6'b000000, 6'b100000, 5'd1, 5'd3, 0, 0, 0);
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic test_perf_counters();
    do_reset();
    checks++;
    if (bus.retired_cnt !== 32'd0 || bus.stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: retired %0d stall %0d expected 0 0", bus.retired_cnt, bus.stall_cnt);
    end
    run_instr("perf_beq", 6'b000100, 6'b000000, 5'd1, 5'd2, 0, 0, 0);
    run_instr("perf_j", 6'b000010, 6'b000000, 5'd0, 5'd0, 0, 0, 0);
    run_instr("perf_sw", 6'b101011, 6'b000000, 5'd3, 5'd0, 0, 3, 0);
    checks++;
    if (bus.retired_cnt !== 32'd3 || bus.stall_cnt !== 32'd3) begin
      errors++;
      $display("FAIL perf_counts: retired %0d stall %0d expected 3 3", bus.retired_cnt, bus.stall_cnt);
    end
  endtask
`endif

  initial begin
    checks        = 0;
    errors        = 0;
    rw_seen       = 0;
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'b000000;
    bus.funct     = 6'b000000;
    bus.rt        = 5'd0;
    bus.rd        = 5'd0;
    fork
      monitor();
    join_none
    test_reset();
    test_r_type();
    test_lw_wait();
    test_zero_dest();
    test_back_to_back();
    test_reset_mid_write();
    test_trap();
`ifdef CTRL_PERF_CNT_EN
    test_perf_counters();
`endif
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending %0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control FSM for the Mini-MIPS datapath. It sits directly upstream of the register file and drives its `reg_write` and `reg_dst` inputs. It also sequences instruction fetch, ALU, memory and PC control. A `mem_ready` handshake stretches the memory states.

## Interface
- `TRAP_HOLD`, default 1: 1 = TRAP is absorbing until reset; 0 = TRAP returns to IDLE after one cycle.
- Reset is asynchronous, active-low: `reset`. Clock: `clk`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous active-low reset.
- `opcode`  in  6  IR[31:26]; sampled in DECODE.
- `funct`  in  6  IR[5:0]; sampled in DECODE.
- `rt`  in  5  IR[20:16]; used for $0 write suppression.
- `rd`  in  5  IR[15:11]; used for $0 write suppression.
- `mem_ready`  in  1  memory has completed the current access.
- `ir_write`  out  1  load instruction register.
- `pc_write`  out  1  unconditional PC update.
- `pc_write_cond`  out  1  PC update if ALU zero.
- `pc_src`  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `iord`  out  1  0 = PC address, 1 = ALUOut address.
- `mem_to_reg`  out  1  write-data select: 1 = MDR.
- `alu_src_a`  out  1  0 = PC, 1 = rs data.
- `alu_src_b`  out  2  00 rt data, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- `alu_op`  out  2  00 add, 01 sub, 10 decode funct.
- `reg_dst`  out  1  1 = rd, 0 = rt.
- `reg_write`  out  1  register file write enable.
- `illegal`  out  1  unsupported instruction trapped.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, ADDI_EXEC, ADDI_WB, JUMP, TRAP.
- All outputs are a Moore decode of a registered state. All outputs are 0 in IDLE.
- IDLE -> FETCH unconditionally.
- FETCH:
  - Outputs: `mem_read`, `ir_write`, `alu_src_b`=01, `pc_write`.
  - `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1.
  - Holds in FETCH while `mem_ready`=0, then -> DECODE.
- DECODE:
  - Outputs: `alu_src_b`=11 (branch target precompute).
  - Dispatch on `opcode`: 000000 -> R_EXEC; 100011 or 101011 -> MEM_ADDR; 000100 -> BRANCH; 001000 -> ADDI_EXEC; 000010 -> JUMP; any other -> TRAP.
  - With opcode 000000, `funct` must be one of 100000, 100010, 100100, 100101, 101010; any other funct -> TRAP.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10. Goes to MEM_RD for lw, MEM_WR for sw (opcode latched in DECODE).
- MEM_RD: `mem_read`, `iord`. Holds until `mem_ready`, then -> MEM_WB.
- MEM_WR: `mem_write`, `iord`. Holds until `mem_ready`, then -> FETCH.
- MEM_WB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`. -> FETCH.
- R_EXEC: `alu_src_a`=1, `alu_op`=10. -> R_WB.
- R_WB: `reg_dst`=1, `reg_write`. -> FETCH.
- ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10. -> ADDI_WB.
- ADDI_WB: `reg_dst`=0, `reg_write`. -> FETCH.
- BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`, `pc_src`=01. -> FETCH.
- JUMP: `pc_write`, `pc_src`=10. -> FETCH.
- TRAP: `illegal`=1, all other outputs 0. Next state is set by `TRAP_HOLD`.
- $0 protection: `reg_write` is forced to 0 in a WB state whose destination (rd if `reg_dst`=1, else rt) is 0. The state sequence is unchanged.

## Timing
- Async assertion of `reset` forces IDLE immediately, even mid-access.
- Any pending `mem_read`/`mem_write` drops within the same cycle as the reset assertion.
- First FETCH is the cycle after reset release.
- Cycles with zero wait: R-type 4, lw 5, sw 4, addi 4, beq 3, j 3.
- Each `mem_ready`=0 cycle adds one cycle in FETCH, MEM_RD or MEM_WR.
- `mem_ready` is ignored in every other state.
- `reg_write` is asserted for exactly one cycle per writing instruction.

## Configuration
- Macro `CTRL_PERF_CNT_EN` defined:
  - Adds output `retired_cnt` (32 bits, reset 0). It increments on every exit from MEM_WB, MEM_WR, R_WB, ADDI_WB, BRANCH and JUMP.
  - Adds output `stall_cnt` (32 bits, reset 0). It increments on every `mem_ready`=0 cycle spent in a memory state.
  - Both counters wrap modulo 2^32.
- Macro not defined: neither port nor counter exists.

## Test plan
- Reset, then `mem_ready`=1, add with rd=3: FETCH, DECODE, R_EXEC, R_WB. `reg_write`=1 and `reg_dst`=1 exactly in the 4th cycle.
- lw with `mem_ready` held 0 for 2 cycles in MEM_RD: 7 cycles total. `mem_to_reg`=1, `reg_dst`=0 in MEM_WB.
- addi with rt=0: ADDI_WB is visited and `reg_write` stays 0 throughout.
- Opcode 111111, `TRAP_HOLD`=1: `illegal`=1 and the FSM stays in TRAP until reset. R-type with funct 000000 also traps.
- `reset` asserted mid-MEM_WR: `mem_write` drops the same cycle. After release, IDLE then FETCH.
- With `CTRL_PERF_CNT_EN`, run beq, j, sw with 3 wait cycles: `retired_cnt`=3, `stall_cnt`=3.
